// File: rtl/filter_tdm_sequencer.sv
// Time-division sequencer that shares one 1-bit filter/decimation datapath across NUM_CH bitstreams.
// It generates sample strobes, window clear/dump commands, and a valid/ready result port with overrun flag.
module filter_tdm_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int DECIM   = 64,
  parameter int CNT_W   = 7,
  parameter int CLK_DIV = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [NUM_CH-1:0] IN,
  output logic              SAMPLE_EN,
  output logic              SAMPLE_BIT,
  output logic [CH_W-1:0]   CH_SEL,
  output logic              ACC_CLR,
  output logic              DUMP,
  input  logic [7:0]        AVG_IN,
  output logic [7:0]        OUT_DATA,
  output logic [CH_W-1:0]   OUT_CH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int PS_W = $clog2(CLK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              start;

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [CNT_W-1:0]  win_q, win_d;

  logic              sample_en_q, sample_en_d;
  logic              sample_bit_q, sample_bit_d;
  logic              acc_clr_q, acc_clr_d;
  logic              dump_q, dump_d;

  logic              cap_pend_q;
  logic [CH_W-1:0]   cap_ch_q, cap_ch_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  // Run control: DRAIN finishes the current window before returning to IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          state_d = S_RUN;
          start   = 1'b1;
        end
      end
      S_RUN: begin
        if (!EN) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dump_q && (ch_sel_q == CH_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot timing: the strobe registers one cycle after the prescaler reaches its last count,
  // and channel/window advance on the strobe cycle so CH_SEL stays valid while SAMPLE_EN is high.
  always_comb begin
    presc_d      = presc_q;
    ch_sel_d     = ch_sel_q;
    win_d        = win_q;
    sample_en_d  = 1'b0;
    sample_bit_d = 1'b0;
    acc_clr_d    = 1'b0;
    dump_d       = 1'b0;
    if (start) begin
      presc_d  = '0;
      ch_sel_d = '0;
      win_d    = '0;
    end else if (state_q != S_IDLE) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
      if (sample_en_q) begin
        ch_sel_d = ch_sel_q + CH_W'(1);
        if (ch_sel_q == CH_LAST) begin
          win_d = (win_q == WIN_LAST) ? '0 : win_q + CNT_W'(1);
        end
      end
      if (presc_q == PS_LAST) begin
        sample_en_d  = 1'b1;
        sample_bit_d = IN[ch_sel_q];
        acc_clr_d    = (win_q == '0);
        dump_d       = (win_q == WIN_LAST);
      end
    end
  end

  // AVG_IN is valid the cycle after DUMP; remember which channel was dumped until then.
  always_comb begin
    cap_ch_d    = dump_q ? ch_sel_q : cap_ch_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (start) begin
      overrun_d = 1'b0;
    end
    if (cap_pend_q) begin
      if (out_valid_q && !OUT_READY) begin
        overrun_d = 1'b1;
      end else begin
        out_data_d  = AVG_IN;
        out_ch_d    = cap_ch_q;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q      <= '0;
      ch_sel_q     <= '0;
      win_q        <= '0;
      sample_en_q  <= 1'b0;
      sample_bit_q <= 1'b0;
      acc_clr_q    <= 1'b0;
      dump_q       <= 1'b0;
      cap_pend_q   <= 1'b0;
      cap_ch_q     <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      ch_sel_q     <= ch_sel_d;
      win_q        <= win_d;
      sample_en_q  <= sample_en_d;
      sample_bit_q <= sample_bit_d;
      acc_clr_q    <= acc_clr_d;
      dump_q       <= dump_d;
      cap_pend_q   <= dump_q;
      cap_ch_q     <= cap_ch_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign SAMPLE_EN  = sample_en_q;
  assign SAMPLE_BIT = sample_bit_q;
  assign CH_SEL     = ch_sel_q;
  assign ACC_CLR    = acc_clr_q;
  assign DUMP       = dump_q;
  assign OUT_DATA   = out_data_q;
  assign OUT_CH     = out_ch_q;
  assign OUT_VALID  = out_valid_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_tdm_sequencer.sv
// Randomized bench for filter_tdm_sequencer against a time-indexed reference model.
// The model derives slot, channel and window position arithmetically from cycles elapsed since start.
module tb_filter_tdm_sequencer;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int DECIM   = 64;
  localparam int CNT_W   = 7;
  localparam int CLK_DIV = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              EN = 1'b0;
  logic [NUM_CH-1:0] IN = '0;
  logic [7:0]        AVG_IN = '0;
  logic              OUT_READY = 1'b0;
  logic              SAMPLE_EN, SAMPLE_BIT, ACC_CLR, DUMP, OUT_VALID, OVERRUN, BUSY;
  logic [CH_W-1:0]   CH_SEL, OUT_CH;
  logic [7:0]        OUT_DATA;

  filter_tdm_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DECIM(DECIM), .CNT_W(CNT_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .IN(IN),
    .SAMPLE_EN(SAMPLE_EN), .SAMPLE_BIT(SAMPLE_BIT), .CH_SEL(CH_SEL),
    .ACC_CLR(ACC_CLR), .DUMP(DUMP), .AVG_IN(AVG_IN),
    .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Stimulus modes: en_mode 0/1 = EN level, 2 = random; rdy_mode 0 = ready, 1 = random, 2 = stalled.
  int en_mode  = 0;
  int rdy_mode = 0;

  // Reference model state.
  bit          busy, drn;
  int unsigned t;
  bit          m_se, m_bit, m_clr, m_dump;
  int          m_ch;
  bit          cap_pend;
  int          cap_ch;
  bit          ov, ovr;
  int          od, och;
  int unsigned n_xfer = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; drn = 0; t = 0;
    m_se = 0; m_bit = 0; m_clr = 0; m_dump = 0; m_ch = 0;
    cap_pend = 0; cap_ch = 0;
    ov = 0; ovr = 0; od = 0; och = 0;
  endtask

  // Advance the model by one clock edge using the input values present before the edge.
  task automatic model_edge();
    bit prev_dump;
    int prev_ch;
    int unsigned n, w;
    prev_dump = m_dump;
    prev_ch   = m_ch;
    if (!busy && EN) ovr = 0;
    if (ov && OUT_READY) begin
      n_xfer++;
      $display("xfer %0d: ch=%0d data=%02h at %0t", n_xfer, och, od, $time);
    end
    if (cap_pend) begin
      if (ov && !OUT_READY) ovr = 1;
      else begin
        od = AVG_IN; och = cap_ch; ov = 1;
      end
    end else if (ov && OUT_READY) begin
      ov = 0;
    end
    cap_pend = prev_dump;
    if (prev_dump) cap_ch = prev_ch;

    if (!busy) begin
      if (EN) begin
        busy = 1; drn = 0; t = 0;
      end
    end else begin
      if (drn && prev_dump && prev_ch == NUM_CH - 1) busy = 0;
      else if (!drn && !EN) drn = 1;
      t++;
    end

    m_se = busy && t > 0 && (t % CLK_DIV) == 0;
    m_clr = 0; m_dump = 0;
    if (m_se) begin
      n     = t / CLK_DIV - 1;
      m_ch  = n % NUM_CH;
      w     = (n / NUM_CH) % DECIM;
      m_clr = (w == 0);
      m_dump = (w == DECIM - 1);
      m_bit = IN[m_ch];
    end
  endtask

  task automatic compare();
    check("busy", BUSY, busy);
    check("sample_en", SAMPLE_EN, m_se);
    check("acc_clr", ACC_CLR, m_clr);
    check("dump", DUMP, m_dump);
    if (m_se) begin
      check("ch_sel", CH_SEL, m_ch);
      check("sample_bit", SAMPLE_BIT, m_bit);
    end
    check("out_valid", OUT_VALID, ov);
    check("overrun", OVERRUN, ovr);
    if (ov) begin
      check("out_data", OUT_DATA, od);
      check("out_ch", OUT_CH, och);
    end
  endtask

  task automatic drive();
    EN     = (en_mode == 2) ? 1'($urandom_range(0, 1)) : (en_mode == 1);
    IN     = NUM_CH'($urandom);
    AVG_IN = 8'($urandom);
    case (rdy_mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = 1'($urandom_range(0, 1));
      default: OUT_READY = 1'b0;
    endcase
  endtask

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      if (RST) model_edge();
      @(negedge CLK);
      compare();
      drive();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch_sel"}, CH_SEL, 0);
    check({tag, "_sample_bit"}, SAMPLE_BIT, 0);
    check({tag, "_out_data"}, OUT_DATA, 0);
    check({tag, "_out_ch"}, OUT_CH, 0);
  endtask

  initial begin
    model_reset();
    RST = 1'b0;
    en_mode = 1;
    rdy_mode = 0;
    drive();
    tick(3);
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b1;

    // Full windows with an always-ready consumer, then random and stalled consumers.
    tick(2 * NUM_CH * DECIM * CLK_DIV + 100);
    rdy_mode = 1;
    tick(NUM_CH * DECIM * CLK_DIV + 50);
    rdy_mode = 2;
    tick(NUM_CH * DECIM * CLK_DIV + 50);

    // Drop EN mid-window: drain to end of window, then stay idle with a pending result draining.
    rdy_mode = 0;
    tick(700);
    en_mode = 0;
    tick(NUM_CH * DECIM * CLK_DIV + 400);

    // Restart (clears OVERRUN), then EN chatter that DRAIN must ignore.
    en_mode = 1;
    rdy_mode = 1;
    tick(500);
    en_mode = 2;
    tick(NUM_CH * DECIM * CLK_DIV + 600);

    // Asynchronous reset mid-window, then restart from channel 0 / window 0.
    en_mode = 1;
    tick(900);
    RST = 1'b0;
    #1;
    model_reset();
    compare();
    check_all_zero("midrst");
    tick(3);
    RST = 1'b1;
    tick(NUM_CH * DECIM * CLK_DIV + 200);
    en_mode = 0;
    rdy_mode = 0;
    tick(NUM_CH * DECIM * CLK_DIV + 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
